oq_regs_req_proc: RTL and testbench

- Downstream consumer of the output-queue register host interface. Takes the held host request (req_in_progress, rd/wr, data, register/queue address) and performs it against the per-queue register store.
- Returns result_ready/reg_result so the host interface can forward the ack onto the udp_reg_grp ring.
- Also owns the datapath counter-update port (read-modify-write add). It serialises host and datapath accesses to one synchronous single-port RAM.

---
 rtl/oq_regs_req_proc.sv | 167 ++++++++++++++++
 tb/tb_oq_regs_req_proc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/oq_regs_req_proc.sv
// Output-queue register store: serves held host requests and datapath counter
// updates (read-modify-write add) against one single-port RAM, one access at a time.
//   state    | meaning
//   S_INIT   | clearing RAM, one word per cycle
//   S_IDLE   | arbitrating host vs update
//   S_H_WAIT | host access issued, RAM data returning
//   S_H_DONE | result_ready pulse
//   S_U_SUM  | update read data returned, sum formed
//   S_U_WR   | update sum written back
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module oq_regs_req_proc #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int NUM_REGS_USED     = 17,
  parameter int ADDR_WIDTH        = $clog2(NUM_REGS_USED),
  parameter int DELTA_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_in_progress,
  input  logic                            reg_rd_wr_L_held,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_held,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [NUM_OQ_WIDTH-1:0]         q_addr,
  output logic                            result_ready,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_result,
  input  logic                            upd_valid,
  output logic                            upd_ready,
  input  logic [NUM_OQ_WIDTH-1:0]         upd_q,
  input  logic [ADDR_WIDTH-1:0]           upd_reg,
  input  logic [DELTA_WIDTH-1:0]          upd_delta,
  output logic                            init_done
);

  localparam int DW    = `CPCI_NF2_DATA_WIDTH;
  localparam int AW    = NUM_OQ_WIDTH + ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int PAD   = DW - DELTA_WIDTH;
  localparam logic [AW-1:0]         LAST_WORD = '1;
  localparam logic [ADDR_WIDTH-1:0] REG_LAST  = ADDR_WIDTH'(NUM_REGS_USED - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_H_WAIT, S_H_DONE, S_U_SUM, S_U_WR
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            init_cnt_q, init_cnt_d;
  logic                     pref_host_q, pref_host_d;
  logic                     host_rd_q, host_rd_d;
  logic [DW-1:0]            host_data_q, host_data_d;
  logic [AW-1:0]            upd_addr_q, upd_addr_d;
  logic [DELTA_WIDTH-1:0]   upd_delta_q, upd_delta_d;
  logic                     upd_ok_q, upd_ok_d;
  logic [DW-1:0]            sum_q, sum_d;
  logic                     result_ready_q, result_ready_d;
  logic [DW-1:0]            reg_result_q, reg_result_d;

  logic [DW-1:0]            mem_q [DEPTH];
  logic [DW-1:0]            ram_rdata_q;
  logic                     ram_we;
  logic [AW-1:0]            ram_addr;
  logic [DW-1:0]            ram_wdata;

  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem_q[ram_addr] <= ram_wdata;
    if (reset) ram_rdata_q <= '0;
    else       ram_rdata_q <= mem_q[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_INIT;
      init_cnt_q     <= '0;
      pref_host_q    <= 1'b0;
      host_rd_q      <= 1'b0;
      host_data_q    <= '0;
      upd_addr_q     <= '0;
      upd_delta_q    <= '0;
      upd_ok_q       <= 1'b0;
      sum_q          <= '0;
      result_ready_q <= 1'b0;
      reg_result_q   <= '0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      pref_host_q    <= pref_host_d;
      host_rd_q      <= host_rd_d;
      host_data_q    <= host_data_d;
      upd_addr_q     <= upd_addr_d;
      upd_delta_q    <= upd_delta_d;
      upd_ok_q       <= upd_ok_d;
      sum_q          <= sum_d;
      result_ready_q <= result_ready_d;
      reg_result_q   <= reg_result_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    pref_host_d    = pref_host_q;
    host_rd_d      = host_rd_q;
    host_data_d    = host_data_q;
    upd_addr_d     = upd_addr_q;
    upd_delta_d    = upd_delta_q;
    upd_ok_d       = upd_ok_q;
    sum_d          = sum_q;
    result_ready_d = 1'b0;
    reg_result_d   = reg_result_q;
    ram_we         = 1'b0;
    ram_addr       = init_cnt_q;
    ram_wdata      = '0;
    upd_ready      = 1'b0;
    case (state_q)
      S_INIT: begin
        ram_we     = 1'b1;
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == LAST_WORD) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Update wins unless the host is waiting and it is the host's turn.
        upd_ready = !req_in_progress || !pref_host_q;
        if (upd_valid && upd_ready) begin
          ram_addr    = {upd_q, upd_reg};
          upd_addr_d  = {upd_q, upd_reg};
          upd_delta_d = upd_delta;
          upd_ok_d    = (upd_reg <= REG_LAST);
          pref_host_d = 1'b1;
          state_d     = S_U_SUM;
        end else if (req_in_progress) begin
          ram_addr    = {q_addr, addr};
          ram_we      = !reg_rd_wr_L_held;
          ram_wdata   = reg_data_held;
          host_rd_d   = reg_rd_wr_L_held;
          host_data_d = reg_data_held;
          pref_host_d = 1'b0;
          state_d     = S_H_WAIT;
        end
      end
      S_H_WAIT: begin
        result_ready_d = 1'b1;
        reg_result_d   = host_rd_q ? ram_rdata_q : host_data_q;
        state_d        = S_H_DONE;
      end
      S_H_DONE: state_d = S_IDLE;
      S_U_SUM: begin
        sum_d   = ram_rdata_q + {{PAD{1'b0}}, upd_delta_q};
        state_d = S_U_WR;
      end
      S_U_WR: begin
        ram_addr  = upd_addr_q;
        ram_we    = upd_ok_q;
        ram_wdata = sum_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign result_ready = result_ready_q;
  assign reg_result   = reg_result_q;
  assign init_done    = (state_q != S_INIT);

endmodule

// File: tb/tb_oq_regs_req_proc.sv
// Self-checking bench for oq_regs_req_proc: directed vectors, arbitration and reset
// sequences, plus randomized traffic checked against a flat word-array model.
module tb_oq_regs_req_proc;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_in_progress;
  logic        reg_rd_wr_L_held;
  logic [31:0] reg_data_held;
  logic [4:0]  addr;
  logic [2:0]  q_addr;
  logic        result_ready;
  logic [31:0] reg_result;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_q;
  logic [4:0]  upd_reg;
  logic [15:0] upd_delta;
  logic        init_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [256];

  typedef struct {
    logic        rd;
    logic [2:0]  q;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] want;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  oq_regs_req_proc dut (
    .clk              (clk),
    .reset            (reset),
    .req_in_progress  (req_in_progress),
    .reg_rd_wr_L_held (reg_rd_wr_L_held),
    .reg_data_held    (reg_data_held),
    .addr             (addr),
    .q_addr           (q_addr),
    .result_ready     (result_ready),
    .reg_result       (reg_result),
    .upd_valid        (upd_valid),
    .upd_ready        (upd_ready),
    .upd_q            (upd_q),
    .upd_reg          (upd_reg),
    .upd_delta        (upd_delta),
    .init_done        (init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
    end
  endtask

  // Call at a negedge; returns at the negedge after the pulse, with the pulse width checked.
  task automatic host_op(input logic rd, input logic [2:0] q, input logic [4:0] r,
                         input logic [31:0] d, output logic [31:0] res, output int lat);
    req_in_progress  = 1'b1;
    reg_rd_wr_L_held = rd;
    reg_data_held    = d;
    q_addr           = q;
    addr             = r;
    lat              = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (result_ready) break;
    end
    res = reg_result;
    req_in_progress = 1'b0;
    chk("host_pulse_seen", {31'b0, result_ready}, 32'd1);
    if (!rd) model[{q, r}] = d;
    @(negedge clk);
    chk("host_pulse_single", {31'b0, result_ready}, 32'd0);
  endtask

  task automatic upd_op(input logic [2:0] q, input logic [4:0] r, input logic [15:0] dl,
                        output bit ok);
    upd_valid = 1'b1;
    upd_q     = q;
    upd_reg   = r;
    upd_delta = dl;
    ok        = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (upd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    upd_valid = 1'b0;
    if (ok && r < 5'd17) model[{q, r}] = model[{q, r}] + {16'b0, dl};
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (!init_done && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (cnt == 128) chk({name, "_upd_ready_low"}, {31'b0, upd_ready}, 32'd0);
    end
    chk({name, "_cycles"}, cnt, 32'd256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [31:0] wd;
    logic [2:0]  q;
    logic [4:0]  r;
    logic [7:0]  a8;
    int          lat;
    int          op;
    bit          ok;

    reset = 1'b1; req_in_progress = 1'b0; reg_rd_wr_L_held = 1'b0; reg_data_held = '0;
    addr = '0; q_addr = '0; upd_valid = 1'b0; upd_q = '0; upd_reg = '0; upd_delta = '0;
    foreach (model[i]) model[i] = '0;

    vecs[0] = '{1'b0, 3'd3, 5'd5, 32'h12345678, 32'h12345678};
    vecs[1] = '{1'b1, 3'd3, 5'd5, 32'h0,        32'h12345678};
    vecs[2] = '{1'b1, 3'd3, 5'd4, 32'h0,        32'h0};
    vecs[3] = '{1'b1, 3'd2, 5'd5, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 3'd1, 5'd0, 32'hFFFFFFF0, 32'hFFFFFFF0};
    vecs[5] = '{1'b1, 3'd1, 5'd0, 32'h0,        32'hFFFFFFF0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result_ready", {31'b0, result_ready}, 32'd0);
    chk("rst_reg_result", reg_result, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_upd_ready", {31'b0, upd_ready}, 32'd0);
    reset = 1'b0;
    wait_init("init");

    host_op(1'b1, 3'd7, 5'd16, 32'h0, res, lat);
    chk("rd_q7r16", res, 32'd0);
    chk("rd_q7r16_latency", lat, 32'd2);

    for (int i = 0; i < 6; i++) begin
      host_op(vecs[i].rd, vecs[i].q, vecs[i].r, vecs[i].d, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].want);
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
    end

    upd_op(3'd1, 5'd0, 16'h0020, ok);
    chk("upd_wrap_ack", {31'b0, ok}, 32'd1);
    host_op(1'b1, 3'd1, 5'd0, 32'h0, res, lat);
    chk("upd_wrap_result", res, 32'h00000010);

    // Both sides held: expect update, host, update, host at 3-cycle spacing.
    req_in_progress = 1'b1; reg_rd_wr_L_held = 1'b1; q_addr = 3'd0; addr = 5'd1;
    upd_valid = 1'b1; upd_q = 3'd0; upd_reg = 5'd2; upd_delta = 16'd1;
    #1;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("arb_upd_ready_c%0d", c), {31'b0, upd_ready},
          (c == 1 || c == 7) ? 32'd1 : 32'd0);
      chk($sformatf("arb_result_ready_c%0d", c), {31'b0, result_ready},
          (c == 6 || c == 12) ? 32'd1 : 32'd0);
      if (c == 6 || c == 12) chk("arb_reg_result", reg_result, model[8'd1]);
      @(negedge clk);
      #1;
    end
    req_in_progress = 1'b0;
    upd_valid = 1'b0;
    model[8'd2] = model[8'd2] + 32'd2;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 2));
      q  = 3'($urandom_range(0, 1));
      r  = 5'(14 + $urandom_range(0, 7));
      case (op)
        0: begin
          host_op(1'b1, q, r, 32'h0, res, lat);
          chk("rand_read", res, model[{q, r}]);
        end
        1: begin
          wd = $urandom;
          host_op(1'b0, q, r, wd, res, lat);
          chk("rand_write_echo", res, wd);
        end
        default: begin
          upd_op(q, r, 16'($urandom), ok);
          chk("rand_upd_ack", {31'b0, ok}, 32'd1);
        end
      endcase
    end

    upd_op(3'd4, 5'd20, 16'h0005, ok);
    chk("oor_upd_ack", {31'b0, ok}, 32'd1);
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      host_op(1'b1, a8[7:5], a8[4:0], 32'h0, res, lat);
      chk($sformatf("readback_%0d", a), res, model[a]);
    end

    host_op(1'b0, 3'd5, 5'd3, 32'hABCD1234, res, lat);
    req_in_progress = 1'b1; reg_rd_wr_L_held = 1'b1; q_addr = 3'd5; addr = 5'd3;
    @(negedge clk);
    reset = 1'b1;
    req_in_progress = 1'b0;
    @(negedge clk);
    chk("midrst_no_pulse", {31'b0, result_ready}, 32'd0);
    chk("midrst_init_done", {31'b0, init_done}, 32'd0);
    chk("midrst_reg_result", reg_result, 32'd0);
    @(negedge clk);
    chk("midrst_no_late_pulse", {31'b0, result_ready}, 32'd0);
    reset = 1'b0;
    foreach (model[i]) model[i] = '0;
    wait_init("reinit");
    host_op(1'b1, 3'd5, 5'd3, 32'h0, res, lat);
    chk("reinit_q5r3", res, 32'd0);
    host_op(1'b1, 3'd3, 5'd5, 32'h0, res, lat);
    chk("reinit_q3r5", res, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
